// File: rtl/btn_debounce_if.sv
// Button conditioning bus: raw buttons in, debounced levels and one-hot events out.
// The debouncer takes the slave modport; whoever drives the buttons takes master.
interface btn_debounce_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;
    logic             busy;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_long, busy
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_long, busy
    );
endinterface

// File: rtl/btn_debounce_ctrl.sv
// Front-panel button synchroniser, per-button debouncer and one-hot press/release/long event FSM.
// Define BTN_LONG_PRESS_EN to build the HELD state, hold counter and btn_long events.
module btn_debounce_ctrl #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int LONG_CYCLES     = 125000000,
    parameter int CNT_W           = 27
) (
    input  logic            clk,
    input  logic            rst_n,
    btn_debounce_if.slave   bus
);
    localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);

    if ((longint'(1) << CNT_W) <= longint'((DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES)) begin : g_cnt_w_check
        $error("btn_debounce_ctrl: CNT_W too small for DEBOUNCE_CYCLES/LONG_CYCLES");
    end

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    typedef enum logic [1:0] {S_IDLE, S_DOWN, S_HELD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DOWN} state_t;
`endif

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_level_d;
    logic [CNT_W-1:0] r_dcnt [N_BTN];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [N_BTN-1:0] r_press,   w_press_nxt;
    logic [N_BTN-1:0] r_release, w_release_nxt;
    logic [N_BTN-1:0] r_long,    w_long_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
`ifdef BTN_LONG_PRESS_EN
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_hcnt_nxt;
`endif

    logic [N_BTN-1:0] w_rise;
    logic             w_any_rise;
    logic [IDX_W-1:0] w_sel;
    logic [N_BTN-1:0] w_sel_oh;
    logic [N_BTN-1:0] w_idx_oh;

    // A new level is accepted only after the synchronised input has differed for
    // DEBOUNCE_CYCLES consecutive counted cycles; any return to the old level restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_level_d <= '0;
            for (int i = 0; i < N_BTN; i++) r_dcnt[i] <= '0;
        end else begin
            r_sync1   <= bus.btn_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DB_LAST) begin
                    r_level[i] <= r_sync2[i];
                    r_dcnt[i]  <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise     = r_level & ~r_level_d;
    assign w_any_rise = |w_rise;

    // Ascending scan: the highest set index overwrites lower ones.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (w_rise[i]) w_sel = IDX_W'(i);
        end
    end

    assign w_sel_oh = N_BTN'(1) << w_sel;
    assign w_idx_oh = N_BTN'(1) << r_idx;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_press_nxt   = '0;
        w_release_nxt = '0;
        w_long_nxt    = '0;
`ifdef BTN_LONG_PRESS_EN
        w_hcnt_nxt    = r_hcnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any_rise) begin
                    w_press_nxt = w_sel_oh;
                    w_idx_nxt   = w_sel;
                    w_state_nxt = S_DOWN;
`ifdef BTN_LONG_PRESS_EN
                    w_hcnt_nxt  = '0;
`endif
                end
            end
            S_DOWN: begin
                // Release wins over a long-press landing in the same cycle.
                if (!r_level[r_idx]) begin
                    w_release_nxt = w_idx_oh;
                    w_state_nxt   = S_IDLE;
                end
`ifdef BTN_LONG_PRESS_EN
                else if (r_hcnt == LONG_LAST) begin
                    w_long_nxt  = w_idx_oh;
                    w_state_nxt = S_HELD;
                end else begin
                    w_hcnt_nxt = r_hcnt + 1'b1;
                end
`endif
            end
`ifdef BTN_LONG_PRESS_EN
            S_HELD: begin
                if (!r_level[r_idx]) begin
                    w_release_nxt = w_idx_oh;
                    w_state_nxt   = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
            r_busy    <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            r_hcnt    <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
            r_busy    <= w_busy_nxt;
`ifdef BTN_LONG_PRESS_EN
            r_hcnt    <= w_hcnt_nxt;
`endif
        end
    end

    assign bus.btn_level   = r_level;
    assign bus.btn_press   = r_press;
    assign bus.btn_release = r_release;
    assign bus.btn_long    = r_long;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Directed bench for btn_debounce_ctrl (N_BTN=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
// Expected events are queued with their due edge when stimulus is applied and checked on arrival.
module tb_btn_debounce_ctrl;
    localparam int N_BTN = 4;
    localparam int DB    = 4;
    localparam int LONG  = 16;

    typedef struct {
        string       tag;
        int          e;
        logic [11:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur;
    logic [11:0] mon_obs;

    btn_debounce_if #(.N_BTN(N_BTN)) bus ();

    btn_debounce_ctrl #(
        .N_BTN(N_BTN),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES(LONG),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [11:0] ev(input int kind, input logic [3:0] v);
        logic [11:0] r;
        r = '0;
        case (kind)
            0:       r[3:0]  = v;
            1:       r[7:4]  = v;
            default: r[11:8] = v;
        endcase
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int e, input int kind, input logic [3:0] v);
        exp_t x;
        x.tag = tag;
        x.e   = e;
        x.vec = ev(kind, v);
        sb.push_back(x);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event monitor: {long, release, press} must match the queue head on its due edge, else be zero.
    always @(negedge clk) begin
        if (edge_n > 0) begin
            mon_obs = {bus.btn_long, bus.btn_release, bus.btn_press};
            if (sb.size() != 0 && sb[0].e <= edge_n) begin
                cur = sb.pop_front();
                checks++;
                assert (mon_obs === cur.vec && cur.e == edge_n) else begin
                    errors++;
                    $error("FAIL %s observed=%03h@edge%0d expected=%03h@edge%0d",
                           cur.tag, mon_obs, edge_n, cur.vec, cur.e);
                end
            end else begin
                checks++;
                assert (mon_obs === 12'h000) else begin
                    errors++;
                    $error("FAIL no_event observed=%03h expected=000 at edge%0d", mon_obs, edge_n);
                end
            end
        end
    end

    initial begin
        int t;
        bus.btn_raw = '0;

        // Reset state
        tick(3);
        chk("rst_level", 32'(bus.btn_level), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_events", 32'({bus.btn_long, bus.btn_release, bus.btn_press}), 32'h0);
        rst_n = 1'b1;
        tick(4);

        // Clean press of button 2
        t = edge_n;
        bus.btn_raw = 4'b0100;
        push("s1_press", t + 8, 0, 4'b0100);
        tick(6);
        chk("s1_level_before", 32'(bus.btn_level), 32'h0);
        tick(1);
        chk("s1_level_rise", 32'(bus.btn_level), 32'h4);
        chk("s1_busy_before", 32'(bus.busy), 32'h0);
        tick(1);
        chk("s1_busy_rise", 32'(bus.busy), 32'h1);
        tick(2);
        t = edge_n;
        bus.btn_raw = '0;
        push("s1_release", t + 8, 1, 4'b0100);
        tick(7);
        chk("s1_level_fall", 32'(bus.btn_level), 32'h0);
        chk("s1_busy_held", 32'(bus.busy), 32'h1);
        tick(1);
        chk("s1_busy_fall", 32'(bus.busy), 32'h0);
        tick(6);

        // Bounce 1,0,1,0 then steady 1 on button 0
        t = edge_n;
        bus.btn_raw = 4'b0001; tick(1);
        bus.btn_raw = 4'b0000; tick(1);
        bus.btn_raw = 4'b0001; tick(1);
        bus.btn_raw = 4'b0000; tick(1);
        bus.btn_raw = 4'b0001;
        push("s2_press", t + 12, 0, 4'b0001);
        tick(6);
        chk("s2_level_still_low", 32'(bus.btn_level), 32'h0);
        tick(1);
        chk("s2_level_rise", 32'(bus.btn_level), 32'h1);
        tick(1);
        t = edge_n;
        bus.btn_raw = '0;
        push("s2_release", t + 8, 1, 4'b0001);
        tick(12);

        // Simultaneous rise of buttons 3 and 1: only 3 reported
        t = edge_n;
        bus.btn_raw = 4'b1010;
        push("s3_press", t + 8, 0, 4'b1000);
        tick(7);
        chk("s3_level_both", 32'(bus.btn_level), 32'ha);
        tick(3);
        bus.btn_raw = 4'b1000;
        tick(1);
        bus.btn_raw = 4'b0000;
        push("s3_release", t + 19, 1, 4'b1000);
        tick(6);
        chk("s3_level_b1_fall", 32'(bus.btn_level), 32'h8);
        tick(1);
        chk("s3_level_b3_fall", 32'(bus.btn_level), 32'h0);
        tick(12);

        // Long hold of button 0
        t = edge_n;
        bus.btn_raw = 4'b0001;
        push("s4_press", t + 8, 0, 4'b0001);
`ifdef BTN_LONG_PRESS_EN
        push("s4_long", t + 8 + LONG, 2, 4'b0001);
`endif
        tick(30);
        chk("s4_busy_hold", 32'(bus.busy), 32'h1);
        chk("s4_level_hold", 32'(bus.btn_level), 32'h1);
        tick(10);
        bus.btn_raw = '0;
        push("s4_release", t + 48, 1, 4'b0001);
        tick(14);
        chk("s4_busy_idle", 32'(bus.busy), 32'h0);

        // Button 3 pressed while button 1 is tracked
        t = edge_n;
        bus.btn_raw = 4'b0010;
        push("s5_press", t + 8, 0, 4'b0010);
        tick(10);
        bus.btn_raw = 4'b1010;
        tick(2);
        bus.btn_raw = 4'b1000;
        push("s5_release", t + 20, 1, 4'b0010);
        tick(4);
        chk("s5_level_b3_before", 32'(bus.btn_level), 32'h2);
        tick(1);
        chk("s5_level_b3_rise", 32'(bus.btn_level), 32'ha);
        tick(4);
        bus.btn_raw = '0;
        tick(12);
        chk("s5_level_all_low", 32'(bus.btn_level), 32'h0);
        chk("s5_busy_idle", 32'(bus.busy), 32'h0);

        // Asynchronous reset mid-hold (hold counter at 9)
        t = edge_n;
        bus.btn_raw = 4'b0001;
        push("s6_press", t + 8, 0, 4'b0001);
        tick(17);
        rst_n = 1'b0;
        #2;
        chk("s6_rst_level", 32'(bus.btn_level), 32'h0);
        chk("s6_rst_busy", 32'(bus.busy), 32'h0);
        chk("s6_rst_events", 32'({bus.btn_long, bus.btn_release, bus.btn_press}), 32'h0);
        tick(1);
        rst_n = 1'b1;
        t = edge_n;
        push("s6_repress", t + 8, 0, 4'b0001);
        tick(6);
        chk("s6_level_before", 32'(bus.btn_level), 32'h0);
        tick(1);
        chk("s6_level_rise", 32'(bus.btn_level), 32'h1);
        tick(3);
        bus.btn_raw = '0;
        push("s6_release", t + 18, 1, 4'b0001);
        tick(14);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
